hex_display_scanner: RTL
========================

Name: hex_display_scanner

Overview:
- Time-multiplexes an N-digit hex value onto a single hex_decoder instance and a bank of common-anode digit drivers.
- Sits directly upstream of the decoder and drives its four control inputs from one nibble.
- Adds per-slot dead-time blanking to prevent ghosting, tear-free frame-synchronous value updates and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 4: digits scanned per frame; must be >= 2.
- PRESCALE, 50000: clk cycles per digit slot.
- BLANK_CYCLES, 16: dead-time cycles at the start of each slot; constraint 1 <= BLANK_CYCLES < PRESCALE.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  hex digits; value[3:0] is digit 0, the least significant.
- load  input  1  one-cycle strobe; captures value into the staging register.
- lz_suppress  input  1  1 = blank leading zero digits.
- nibble  output  4  digit code to the decoder; nibble[3] drives c0, nibble[2] c1, nibble[1] c2, nibble[0] c3.
- digit_an_n  output  NUM_DIGITS  active-low anode enables; bit i selects digit i.
- blank  output  1  1 = no anode active this cycle.
- frame_tick  output  1  one-cycle pulse on the first cycle of slot 0 of each frame.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - slot_cnt=0, digit_idx=0, state=S_BLANK.
  - shadow=0, staging=0, pending=0.
  - nibble=0, digit_an_n=all 1s, blank=1, frame_tick=0.
- Reset asserted mid-slot aborts the slot immediately. The cycle after reset release is cycle 0 of slot 0.
- Slot counter:
  - slot_cnt counts 0..PRESCALE-1 and then wraps to 0.
  - Width is $clog2(PRESCALE).
  - On wrap, digit_idx advances modulo NUM_DIGITS.
- State machine, evaluated per slot:
  - S_BLANK covers slot_cnt < BLANK_CYCLES: digit_an_n all 1s, blank=1.
  - S_SHOW covers slot_cnt >= BLANK_CYCLES: exactly one anode low (digit_an_n[digit_idx]=0) unless the digit is suppressed; blank=0 when an anode is low.
  - S_BLANK -> S_SHOW when slot_cnt reaches BLANK_CYCLES.
  - S_SHOW -> S_BLANK on slot wrap.
- nibble:
  - Equals shadow[4*digit_idx +: 4] throughout the slot, including dead time, so decoder inputs settle before the anode turns on.
  - Updates on the same edge as the digit_idx change.
- Leading-zero suppression:
  - Applies only when lz_suppress=1.
  - Digit i (i >= 1) is suppressed when digits NUM_DIGITS-1 down to i of shadow are all zero.
  - Digit 0 is never suppressed.
  - A suppressed slot keeps all anodes high and blank=1 for the whole slot.
- Load and update:
  - load=1: staging <= value and pending <= 1.
  - A second load while pending overwrites staging, last wins.
  - At the frame boundary (the cycle slot_cnt wraps with digit_idx=NUM_DIGITS-1): if pending, shadow <= staging and pending <= 0.
  - load asserted on the boundary cycle itself: shadow <= value directly and pending stays 0.
  - shadow never changes mid-frame.
- frame_tick:
  - 1 for exactly one cycle when slot_cnt=0 and digit_idx=0.
  - Also 1 on the first cycle after reset release.
- Frame period is NUM_DIGITS*PRESCALE cycles, with no stalls.

Decomposition:
- Package hex_display_pkg:
  - Scan-state enum (S_BLANK, S_SHOW).
  - Function computing the leading-zero mask from the shadow vector and NUM_DIGITS.
  - Constant NIBBLE_W=4.
- Sub-module scan_timer (parameters PRESCALE, NUM_DIGITS): owns slot_cnt and digit_idx; emits slot_wrap, frame_wrap and in_blank.
- The top level owns the shadow/staging registers, the suppression logic and the output registers.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
1. Reset held 3 cycles, then released with no load -> digit_an_n=4'b1111 and blank=1 during reset; cycles 2-7 after release: digit_an_n=4'b1110, nibble=0; frame_tick=1 on cycle 0 and cycle 32 only.
2. load with value=16'hA5C3, then run 2 frames -> shadow updates at the next frame boundary; next frame slots show nibble 3, C, 5, A with anodes 1110, 1101, 1011, 0111 at slot cycles 2-7; slot cycles 0-1 all 1111.
3. load with 16'h1234 at mid-frame cycle 13, then load 16'h5678 at cycle 20 -> current frame still shows the old value; next frame shows 8, 7, 6, 5.
4. load with 16'h00BE asserted exactly on a boundary cycle -> the immediately following frame shows E, B, 0, 0 with pending=0.
5. lz_suppress=1, value 16'h0000 then 16'h0090 -> first case: only digit 0 lights (1110), other slots 1111 with blank=1; second case: digits 0 and 1 light, digits 2 and 3 blank.
6. reset asserted at slot 2, cycle 5 -> next cycle all outputs at reset values; after release, scanning restarts at digit 0, cycle 0, shadow=0.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and helpers for the multiplexed hex display scanner.
package hex_display_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 16;

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } scan_state_e;

    // Bit i is set when digit i and every digit above it are zero; digit 0 is never flagged.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [NIBBLE_W*MAX_DIGITS-1:0] digits,
        input int                             num_digits
    );
        logic upper_zero;
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                upper_zero = upper_zero && (digits[NIBBLE_W*i +: NIBBLE_W] == '0);
                lz_mask[i] = upper_zero;
            end
        end
    endfunction

endpackage

// File: rtl/hex_display_scanner_scan_timer.sv
// Slot/digit timebase for the scanner; publishes the position entered at the next edge
// so the owner can register its outputs in step with the counters.
module scan_timer #(
    parameter int PRESCALE     = 50000,
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [$clog2(PRESCALE)-1:0]   next_slot,
    output logic [$clog2(NUM_DIGITS)-1:0] next_idx,
    output logic                          slot_wrap,
    output logic                          frame_wrap,
    output logic                          in_blank
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic             active;

    // NOTE: combinational blocks assign every output first so no path can infer a latch.
    always_comb begin
        slot_wrap  = active && (slot_cnt == LAST_SLOT);
        frame_wrap = slot_wrap && (digit_idx == LAST_IDX);
        next_slot  = slot_cnt;
        next_idx   = digit_idx;
        if (slot_wrap) begin
            next_slot = '0;
            next_idx  = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
        end else if (active) begin
            next_slot = slot_cnt + 1'b1;
        end
        in_blank = next_slot < CNT_W'(BLANK_CYCLES);
    end

    // The first edge after reset enters slot 0 without advancing, so the counters line up with the outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            active    <= 1'b0;
        end else begin
            slot_cnt  <= next_slot;
            digit_idx <= next_idx;
            active    <= 1'b1;
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex scanner with dead-time blanking, frame-synchronous value
// updates and optional leading-zero suppression.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    input  logic                           load,
    input  logic                           lz_suppress,
    output logic [NIBBLE_W-1:0]            nibble,
    output logic [NUM_DIGITS-1:0]          digit_an_n,
    output logic                           blank,
    output logic                           frame_tick
);
    localparam int W     = NIBBLE_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]             next_slot;
    logic [IDX_W-1:0]             next_idx;
    logic                         slot_wrap, frame_wrap, in_blank;
    logic [W-1:0]                 shadow, staging, shadow_next;
    logic                         pending;
    scan_state_e                  state, state_next;
    logic [NIBBLE_W*MAX_DIGITS-1:0] digits_ext;
    logic [MAX_DIGITS-1:0]        lz_bits, idx_onehot;
    logic                         suppress_next;
    logic [NUM_DIGITS-1:0]        an_next;

    scan_timer #(
        .PRESCALE     (PRESCALE),
        .NUM_DIGITS   (NUM_DIGITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .next_slot  (next_slot),
        .next_idx   (next_idx),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap),
        .in_blank   (in_blank)
    );

    // A load on the boundary cycle bypasses staging so it shows in the very next frame.
    always_comb begin
        shadow_next = shadow;
        if (frame_wrap) begin
            if (load)         shadow_next = value;
            else if (pending) shadow_next = staging;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            staging <= '0;
            pending <= 1'b0;
        end else begin
            shadow <= shadow_next;
            if (load) staging <= value;
            if (frame_wrap)  pending <= 1'b0;
            else if (load)   pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_BLANK;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_BLANK: if (!in_blank) state_next = S_SHOW;
            S_SHOW:  if (slot_wrap) state_next = S_BLANK;
            default: state_next = S_BLANK;
        endcase
    end

    always_comb begin
        digits_ext            = '0;
        digits_ext[W-1:0]     = shadow_next;
        lz_bits               = lz_mask(digits_ext, NUM_DIGITS);
        idx_onehot            = MAX_DIGITS'(1) << next_idx;
        suppress_next         = lz_suppress && |(lz_bits & idx_onehot);
        an_next               = '1;
        if (state_next == S_SHOW && !suppress_next) an_next[next_idx] = 1'b0;
    end

    // Outputs are registered from the position being entered, so they align with the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            nibble     <= '0;
            digit_an_n <= '1;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            nibble     <= shadow_next[NIBBLE_W*next_idx +: NIBBLE_W];
            digit_an_n <= an_next;
            blank      <= &an_next;
            frame_tick <= (next_slot == '0) && (next_idx == '0);
        end
    end

endmodule
